// File: rtl/if_id_stage_if.sv
// Signal bundle between the IF/ID boundary and its neighbours: IF bus, stall/flush
// controls and instruction SRAM data in; the ID-facing instruction slot out.
interface if_id_stage_if #(
  parameter int IF_TO_ID_WD = 33,
  parameter int STALL_WD    = 6
);
  logic [STALL_WD-1:0]    stall;
  logic                   flush;
  logic [IF_TO_ID_WD-1:0] if_to_id_bus;
  logic [31:0]            inst_sram_rdata;
  logic                   id_valid;
  logic [31:0]            id_pc;
  logic [31:0]            id_inst;
  logic                   inst_held;

  modport master (
    output stall, flush, if_to_id_bus, inst_sram_rdata,
    input  id_valid, id_pc, id_inst, inst_held
  );

  modport slave (
    input  stall, flush, if_to_id_bus, inst_sram_rdata,
    output id_valid, id_pc, id_inst, inst_held
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: latches {ce, pc}, pairs it with the synchronous SRAM word,
// and keeps that word in a one-entry hold buffer while ID is stalled.
module if_id_stage #(
  parameter int IF_TO_ID_WD = 33,
  parameter int STALL_WD    = 6
) (
  input  logic            clk,
  input  logic            rst,
  if_id_stage_if.slave    io
);

  typedef enum logic {LIVE = 1'b0, HELD = 1'b1} buf_state_e;

  buf_state_e  state_q, state_d;
  logic        valid_q, valid_d;
  logic        fresh_q, fresh_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;

  logic        if_ce;
  logic [31:0] if_pc;
  logic        adv, bubble;

  assign if_ce  = io.if_to_id_bus[IF_TO_ID_WD-1];
  assign if_pc  = io.if_to_id_bus[31:0];
  assign adv    = !io.stall[1];
  assign bubble = io.stall[1] && !io.stall[2];

  // Only stall bits 1 and 2 concern this boundary.
  logic unused_stall;
  assign unused_stall = ^{io.stall[0], io.stall[STALL_WD-1:3]};

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    fresh_d = fresh_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    if (io.flush) begin
      valid_d = 1'b0;
      fresh_d = 1'b0;
      state_d = LIVE;
    end else if (adv) begin
      pc_d    = if_pc;
      valid_d = if_ce;
      fresh_d = if_ce;
      state_d = LIVE;
    end else if (bubble) begin
      valid_d = 1'b0;
      fresh_d = 1'b0;
      state_d = LIVE;
    end else begin
      // Hold: the SRAM word is only on the bus in the first stalled cycle, so grab it then.
      fresh_d = 1'b0;
      if (state_q == LIVE && fresh_q && valid_q) begin
        state_d = HELD;
        buf_d   = io.inst_sram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LIVE;
      valid_q <= 1'b0;
      fresh_q <= 1'b0;
      pc_q    <= 32'h0;
      buf_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      fresh_q <= fresh_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  assign io.id_valid  = valid_q;
  assign io.id_pc     = pc_q;
  assign io.inst_held = (state_q == HELD);
  assign io.id_inst   = valid_q ? ((state_q == HELD) ? buf_q : io.inst_sram_rdata) : 32'h0;

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized scoreboard bench for if_id_stage: a slot-level model predicts what ID
// should see each cycle; a negedge monitor pops and compares.
module tb_if_id_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_id_stage_if #(.IF_TO_ID_WD(33), .STALL_WD(6)) bus ();
  if_id_stage #(.IF_TO_ID_WD(33), .STALL_WD(6)) dut (.clk(clk), .rst(rst), .io(bus.slave));

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        held;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Model of the ID slot: what entry it holds, whether its SRAM word is on the bus
  // right now, and whether it has sat through a stall edge.
  logic        m_known = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_pc    = '0;
  logic        m_fresh = 1'b0;
  logic        m_held  = 1'b0;
  logic [31:0] junk    = 32'hDEADBEEF;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h24080001;
    if (a == 32'hBFC00004) return 32'h8C090000;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("id_valid",  {31'h0, bus.id_valid},  {31'h0, e.valid});
      check("id_pc",     bus.id_pc,              e.pc);
      check("id_inst",   bus.id_inst,            e.inst);
      check("inst_held", {31'h0, bus.inst_held}, {31'h0, e.held});
    end
  end

  // One cycle: present this cycle's SRAM data, record what ID must show, drive the
  // controls for the next edge, then advance the model across that edge.
  task automatic step(input logic r, input logic f, input logic [5:0] st,
                      input logic ce, input logic [31:0] pc);
    exp_t e;
    bus.inst_sram_rdata = m_fresh ? mem_word(m_pc) : junk;
    if (m_known) begin
      e.valid = m_valid;
      e.pc    = m_pc;
      e.inst  = m_valid ? mem_word(m_pc) : 32'h0;
      e.held  = m_held;
      exp_q.push_back(e);
    end
    rst = r;
    bus.flush = f;
    bus.stall = st;
    bus.if_to_id_bus = {ce, pc};
    @(posedge clk);
    if (r) begin
      m_known = 1'b1; m_valid = 1'b0; m_pc = '0; m_fresh = 1'b0; m_held = 1'b0;
    end else if (f) begin
      m_valid = 1'b0; m_fresh = 1'b0; m_held = 1'b0;
    end else if (!st[1]) begin
      m_pc = pc; m_valid = ce; m_fresh = ce; m_held = 1'b0;
    end else if (!st[2]) begin
      m_valid = 1'b0; m_fresh = 1'b0; m_held = 1'b0;
    end else begin
      m_held  = m_valid;
      m_fresh = 1'b0;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.stall = '0;
    bus.if_to_id_bus = '0;
    bus.inst_sram_rdata = '0;

    // reset then normal fetch
    step(1, 0, 6'b000000, 0, 32'h0);
    step(1, 0, 6'b000000, 0, 32'h0);
    step(0, 0, 6'b000000, 1, 32'hBFC00000);
    // three-cycle ID stall; later SRAM reads are junk
    step(0, 0, 6'b000000, 1, 32'hBFC00004);
    step(0, 0, 6'b000111, 1, 32'hBFC00008);
    step(0, 0, 6'b000111, 1, 32'hBFC00008);
    step(0, 0, 6'b000111, 1, 32'hBFC00008);
    step(0, 0, 6'b000000, 1, 32'hBFC00008);
    // bubble
    step(0, 0, 6'b000011, 1, 32'hBFC0000C);
    step(0, 0, 6'b000000, 1, 32'hBFC0000C);
    // flush during hold
    step(0, 0, 6'b000000, 1, 32'hBFC00010);
    step(0, 0, 6'b000111, 1, 32'hBFC00014);
    step(0, 0, 6'b000111, 1, 32'hBFC00014);
    step(0, 1, 6'b000111, 1, 32'hBFC00014);
    step(0, 0, 6'b000000, 1, 32'hBFC00380);
    // invalid fetch, then holds that must not latch anything
    step(0, 0, 6'b000000, 0, 32'hBFC00384);
    step(0, 0, 6'b000111, 1, 32'hBFC00388);
    step(0, 0, 6'b000111, 1, 32'hBFC00388);
    // flush and advance together: incoming entry dropped
    step(0, 0, 6'b000000, 1, 32'hFFFFFFFC);
    step(0, 1, 6'b000000, 1, 32'hBFC00400);
    // reset mid-hold
    step(0, 0, 6'b000000, 1, 32'hBFC00500);
    step(0, 0, 6'b000111, 1, 32'hBFC00504);
    step(0, 0, 6'b000111, 1, 32'hBFC00504);
    step(1, 0, 6'b000111, 1, 32'hBFC00504);
    step(0, 0, 6'b000000, 1, 32'hFFFFFFFC);

    for (int i = 0; i < 400; i++) begin
      logic [5:0]  st;
      logic [31:0] pc;
      int          k;
      junk = $urandom;
      k = $urandom_range(0, 9);
      st = (k < 5) ? 6'b000000 : (k < 7) ? 6'b000011 : 6'b000111;
      st[0] = st[1];
      st[5:3] = 3'($urandom);
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
      step($urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0, st,
           $urandom_range(0, 4) != 0, pc);
    end

    step(0, 0, 6'b000000, 0, 32'h0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

IF/ID pipeline boundary for the 5-stage MIPS core. It sits between the IF stage (`{ce, pc}` bus) and the ID stage. It registers the fetch PC and valid bit, and pairs them with the synchronous instruction-SRAM read data. A one-entry instruction hold buffer keeps the fetched word intact while ID is stalled, so no instruction is lost or duplicated across stalls and flushes.

## Interface
- `IF_TO_ID_WD`, 33, width of IF bus `{ce, pc[31:0]}`
- `STALL_WD`, 6, width of the stall vector (`StallBus`)
- `clk  in  1  clock`
- `rst  in  1  reset, synchronous, active-high`
- `stall  in  STALL_WD  stall vector; bit1 = IF/ID boundary stalled, bit2 = ID stalled`
- `flush  in  1  exception/eret flush; kills the instruction held at this boundary`
- `if_to_id_bus  in  IF_TO_ID_WD  {ce, pc} from IF, registered by IF`
- `inst_sram_rdata  in  32  instruction SRAM read data, valid one cycle after the address`
- `id_valid  out  1  ID holds a real instruction`
- `id_pc  out  32  PC of the instruction in ID`
- `id_inst  out  32  instruction word for ID; 0 when id_valid=0`
- `inst_held  out  1  id_inst is sourced from the hold buffer`

## Operation
- Registers: `valid_r`, `pc_r[31:0]`, `fresh_r` (SRAM word for `pc_r` is on `inst_sram_rdata` this cycle), `buf_r[31:0]`, `buf_v`.
- Boundary update, evaluated in priority order each posedge:
  1. `rst`: `valid_r`=0, `pc_r`=0, `fresh_r`=0, `buf_v`=0, `buf_r`=0.
  2. `flush`: `valid_r`=0, `fresh_r`=0, `buf_v`=0. `pc_r` is unchanged.
  3. `stall[1]`=0 (advance): `pc_r`←pc, `valid_r`←ce, `fresh_r`←ce, `buf_v`←0.
  4. `stall[1]`=1, `stall[2]`=0 (IF held, ID proceeds): insert a bubble. `valid_r`=0, `fresh_r`=0, `buf_v`=0.
  5. `stall[1]`=1, `stall[2]`=1 (hold): `pc_r` and `valid_r` are unchanged.
- Hold buffer FSM, two states:
  - **LIVE**: `buf_v`=0.
  - **HELD**: `buf_v`=1.
- LIVE→HELD when a hold (case 5) occurs while `fresh_r`=1 and `valid_r`=1. The transition captures `buf_r`←`inst_sram_rdata` and clears `fresh_r`.
- A hold while `fresh_r`=0 keeps LIVE. This case only arises for invalid entries.
- HELD→LIVE on advance, bubble, flush or rst. HELD is otherwise sticky through any number of consecutive hold cycles.
- Output mux:
  - `id_inst` = `valid_r` ? (`buf_v` ? `buf_r` : `inst_sram_rdata`) : 32'h0.
  - `id_valid`=`valid_r`, `id_pc`=`pc_r`, `inst_held`=`buf_v`.
- `fresh_r` is a one-cycle flag. It is never 1 for more than one consecutive cycle without an intervening advance.

## Timing
- Outputs after reset: `id_valid`=0, `id_pc`=0, `id_inst`=0, `inst_held`=0.
- PC path: IF presents `{ce, pc}` in cycle N. In cycle N+1, `id_pc`=pc and `id_valid`=ce.
- Instruction path:
  - `id_inst` is combinational from `inst_sram_rdata` in cycle N+1, which is the SRAM read of the cycle-N address.
  - From the second stalled cycle onward, `id_inst` comes from the buffer, with zero added latency.
- Stall semantics:
  - Hold duration is unbounded.
  - `id_inst` is constant throughout the hold and equals the word read for `pc_r`, regardless of SRAM address changes.
- Flush behaviour:
  - Flush takes effect at the next edge and overrides any stall.
  - The cycle after a flush shows `id_valid`=0.
  - Flush and advance in the same cycle: the flush wins, and the incoming IF entry is dropped.
- Reset mid-hold clears HELD in one cycle.
- PC width: `pc_r` is a straight 32-bit copy with no arithmetic. 0xFFFFFFFC passes unchanged.

## Test plan
- **Reset, then normal fetch:** hold `rst` 2 cycles; IF drives ce=1, pc=0xBFC00000; rdata=0x24080001 next cycle. Required: `id_valid`=1, `id_pc`=0xBFC00000, `id_inst`=0x24080001, `inst_held`=0.
- **Three-cycle ID stall:** stall=6'b000111 for 3 cycles after pc=0xBFC00004 is loaded (rdata=0x8C090000 in cycle 1, then junk 0xDEADBEEF). Required: `id_inst`=0x8C090000 all 3 cycles, and `inst_held`=1 from the 2nd cycle. On release, advance to pc 0xBFC00008 with `inst_held`=0.
- **Bubble insertion:** stall=6'b000011 (IF/IF-ID stalled, ID free) for one cycle. Required: next cycle `id_valid`=0 and `id_inst`=0; then resume with the IF PC.
- **Flush during hold:** in HELD state assert `flush` together with stall=6'b000111. Required: next cycle `id_valid`=0 and `inst_held`=0. Subsequent advance loads the new IF PC (e.g. 0xBFC00380 with ce=1).
- **Invalid fetch:** ce=0 with stall=0. Required: `id_valid`=0 and `id_inst`=0 regardless of rdata; a following hold never enters HELD.
- **Reset mid-hold:** `rst` asserted in HELD. Required: all outputs 0 on the next cycle.
